// File: rtl/axis_pl_to_ps_bridge.sv
// axis_pl_to_ps_bridge
//   Single-clock AXI-Stream width-down converter. Wide words from the ADC
//   control logic are buffered in a show-ahead synchronous FIFO. A serializer
//   then emits each word as RATIO narrow beats, least-significant slice first.
//   Both sides support full backpressure.
//   IN_WIDTH must equal OUT_WIDTH * RATIO.
//
// Ports
//   clk, rst              single clock; synchronous active-high reset
//   s_axis_tdata/tvalid   wide input word; s_axis_tready = !full && !rst
//   m_axis_tdata/tvalid   narrow output beat; both are driven from flops only
//   m_axis_tready         output ready from the PS side
module axis_pl_to_ps_bridge #(
    parameter int IN_WIDTH        = 128,
    parameter int OUT_WIDTH       = 32,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(RATIO - 1);

    // ---------------------------------------------------------------- FIFO
    logic [IN_WIDTH-1:0]        mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic                       full, empty, push, pop;

    assign full          = (count == DEPTH_CNT);
    assign empty         = (count == '0);
    // Readiness depends only on occupancy, so a pop on the same edge does not
    // free space for a write when the FIFO is full.
    assign s_axis_tready = !full && !rst;
    assign push          = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    // pop is only raised by the serializer when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------- serializer
    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state, state_nxt;
    logic [RATIO-1:0][OUT_WIDTH-1:0] word_q;
    logic [IDX_W-1:0]              idx_q, idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            if (pop) begin
                word_q <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = SEND;
                    pop       = 1'b1;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        // Chain straight into the next word to keep one beat
                        // per cycle; otherwise fall back to idle.
                        if (!empty) begin
                            pop     = 1'b1;
                            idx_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = (state == SEND) ? word_q[idx_q] : '0;

endmodule

// File: tb/tb_axis_pl_to_ps_bridge.sv
module tb_axis_pl_to_ps_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    axis_pl_to_ps_bridge #(
        .IN_WIDTH(128), .OUT_WIDTH(32), .FIFO_ADDR_WIDTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];      // expected beat stream, in order
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    typedef struct {
        logic         rst;
        logic         sv;
        logic [127:0] sd;
        logic         mr;
        logic         str;
        logic         mv;
        logic [31:0]  md;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic v, logic [127:0] d, logic m,
                                logic s, logic mvv, logic [31:0] mdd);
        vec_t x;
        x.rst = r; x.sv = v; x.sd = d; x.mr = m;
        x.str = s; x.mv = mvv; x.md = mdd;
        return x;
    endfunction

    function automatic logic [127:0] word(int k);
        logic [31:0] b;
        b = 32'(k << 4);
        return {b | 32'h3, b | 32'h2, b | 32'h1, b};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge with inputs already driven. Scores the
    // handshakes that the coming edge will perform, then advances one cycle.
    task automatic tick();
        logic was_rst;
        was_rst = rst;
        if (!rst) begin
            if (prev_stall) begin
                chk("stable_valid", m_axis_tvalid, 1'b1);
                chk("stable_data", m_axis_tdata, prev_data);
            end
            if (s_axis_tvalid && s_axis_tready)
                for (int b = 0; b < 4; b++) exp_q.push_back(s_axis_tdata[b*32 +: 32]);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", m_axis_tdata, 128'hx);
                end else begin
                    chk("beat", m_axis_tdata, exp_q.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end
    endtask

    task automatic drain(string nm);
        rst = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < 400 && (m_axis_tvalid || exp_q.size() != 0); i++) tick();
        chk({nm, "_idle"}, m_axis_tvalid, 1'b0);
        chk({nm, "_left"}, exp_q.size(), 0);
    endtask

    task automatic fill17();
        m_axis_tready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = word(k);
            chk("fill_ready", s_axis_tready, 1'b1);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] w0, w1, cur;
        int           acc, cyc;
        logic         have;

        w0 = 128'h00001111222233334444555566667777;
        w1 = 128'h88889999AAAABBBBCCCCDDDDEEEEFFFF;

        // Reset rows, release rows, then the two-word back-to-back case.
        for (int i = 0; i < 10; i++) tv.push_back(mk(1, 1, w1, 1, 0, 0, 32'h0));
        for (int i = 0; i < 3; i++)  tv.push_back(mk(0, 0, '0, 1, 1, 0, 32'h0));
        tv.push_back(mk(0, 1, w0, 1, 1, 0, 32'h0));
        tv.push_back(mk(0, 1, w1, 1, 1, 0, 32'h0));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'h66667777));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'h44445555));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'h22223333));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'h00001111));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'hEEEEFFFF));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'hCCCCDDDD));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'hAAAABBBB));
        tv.push_back(mk(0, 0, '0, 1, 1, 1, 32'h88889999));
        tv.push_back(mk(0, 0, '0, 1, 1, 0, 32'h0));

        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            rst = tv[i].rst; s_axis_tvalid = tv[i].sv;
            s_axis_tdata = tv[i].sd; m_axis_tready = tv[i].mr;
            #0;
            chk($sformatf("vec%0d_sready", i), s_axis_tready, tv[i].str);
            chk($sformatf("vec%0d_mvalid", i), m_axis_tvalid, tv[i].mv);
            chk($sformatf("vec%0d_mdata", i), m_axis_tdata, tv[i].md);
            tick();
        end

        // Stalled sink: 1 held + 16 buffered, then drain 68 beats.
        fill17();
        w0 = word(0);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_full", s_axis_tready, 1'b0);
            chk("stall_valid", m_axis_tvalid, 1'b1);
            chk("stall_first", m_axis_tdata, w0[31:0]);
            tick();
        end
        m_axis_tready = 1'b1;
        for (int b = 0; b < 68; b++) begin
            chk("drain68_valid", m_axis_tvalid, 1'b1);
            if (b == 3) chk("drain_still_full", s_axis_tready, 1'b0);
            if (b == 4) chk("drain_ready_back", s_axis_tready, 1'b1);
            tick();
        end
        chk("drain68_done", m_axis_tvalid, 1'b0);
        chk("drain68_left", exp_q.size(), 0);

        // Full boundary: write attempted on the pop edge is refused.
        fill17();
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 128'hFEED_0000_FEED_1111_FEED_2222_FEED_3333;
        for (int b = 0; b < 4; b++) begin
            chk("bound_refused", s_axis_tready, 1'b0);
            tick();
        end
        chk("bound_accept", s_axis_tready, 1'b1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("bound_full_again", s_axis_tready, 1'b0);
        drain("bound");

        // Mid-stream reset after two beats.
        s_axis_tvalid = 1'b1; s_axis_tdata = w0; m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_valid", m_axis_tvalid, 1'b0);
        chk("mrst_data", m_axis_tdata, 32'h0);
        chk("mrst_sready", s_axis_tready, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mrst_no_residual", m_axis_tvalid, 1'b0);
            tick();
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = w1;
        tick();
        s_axis_tvalid = 1'b0;
        chk("mrst_latency", m_axis_tvalid, 1'b0);
        tick();
        chk("mrst_new_valid", m_axis_tvalid, 1'b1);
        chk("mrst_new_low", m_axis_tdata, 32'hEEEEFFFF);
        drain("mrst");

        // Random traffic against the beat scoreboard.
        acc = 0; cyc = 0; have = 1'b0; cur = '0;
        while (acc < 1000 && cyc < 20000) begin
            if (!have) begin
                cur  = rnd128();
                have = ($urandom % 4) != 0;
            end
            s_axis_tvalid = have;
            s_axis_tdata  = cur;
            m_axis_tready = ($urandom % 3) != 0;
            #0;
            if (s_axis_tvalid && s_axis_tready) begin
                acc++;
                have = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("rand_accepted", acc, 1000);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 6000 && (m_axis_tvalid || exp_q.size() != 0); i++) begin
            m_axis_tready = ($urandom % 3) != 0;
            tick();
        end
        chk("rand_idle", m_axis_tvalid, 1'b0);
        chk("rand_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
